// File: rtl/dz_pkg.sv
// Shared types and constants for the dz_scan_ctrl dot-matrix scan controller.
package dz_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } dz_state_e;

    // Pixel colour: bit 0 drives colr, bit 1 drives colg.
    typedef enum logic [1:0] {
        PIX_OFF    = 2'b00,
        PIX_RED    = 2'b01,
        PIX_GREEN  = 2'b10,
        PIX_YELLOW = 2'b11
    } dz_pix_e;

    // Level of an unselected row line.
    localparam logic ROW_OFF = 1'b1;

endpackage

// File: rtl/dz_scan_ctrl_if.sv
// Back-buffer write and swap bus between the hatch-stage FSM and the scan controller.
interface dz_scan_ctrl_if #(
    parameter int unsigned ROWS = 8,
    parameter int unsigned COLS = 8
);
    localparam int unsigned RW = $clog2(ROWS);

    logic            wr_en;
    logic [RW-1:0]   wr_row;
    logic [COLS-1:0] wr_r;
    logic [COLS-1:0] wr_g;
    logic            swap;
    logic            swap_done;

    modport master (output wr_en, wr_row, wr_r, wr_g, swap, input swap_done);
    modport slave  (input wr_en, wr_row, wr_r, wr_g, swap, output swap_done);

endinterface

// File: rtl/dz_frame_buf.sv
// Double-buffered frame store: writes always hit the back bank, reads return the
// front bank as it will be after this edge's optional flip.
module dz_frame_buf
    import dz_pkg::*;
#(
    parameter int unsigned ROWS = 8,
    parameter int unsigned COLS = 8,
    localparam int unsigned RW  = $clog2(ROWS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic [RW-1:0]   wr_row,
    input  logic [COLS-1:0] wr_r,
    input  logic [COLS-1:0] wr_g,
    input  logic            flip,
    input  logic [RW-1:0]   rd_row,
    output logic [COLS-1:0] rd_r_c,
    output logic [COLS-1:0] rd_g_c
);

    logic            front_sel_q;
    logic [COLS-1:0] mem_r [2][ROWS];
    logic [COLS-1:0] mem_g [2][ROWS];
    logic            back_sel;
    logic            wr_ok;
    logic            rd_sel;
    logic            hit;

    assign back_sel = ~front_sel_q;
    assign wr_ok    = wr_en && ({1'b0, wr_row} < (RW+1)'(ROWS));

    // A flip promotes the current back bank, so a same-cycle write to it must be forwarded.
    assign rd_sel = front_sel_q ^ flip;
    assign hit    = flip && wr_ok && (wr_row == rd_row);
    assign rd_r_c = hit ? wr_r : mem_r[rd_sel][rd_row];
    assign rd_g_c = hit ? wr_g : mem_g[rd_sel][rd_row];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            front_sel_q <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < ROWS; r++) begin
                    mem_r[b][r] <= '0;
                    mem_g[b][r] <= '0;
                end
            end
        end else begin
            if (flip) front_sel_q <= ~front_sel_q;
            if (wr_ok) begin
                mem_r[back_sel][wr_row] <= wr_r;
                mem_g[back_sel][wr_row] <= wr_g;
            end
        end
    end

endmodule

// File: rtl/dz_scan_ctrl.sv
// Row-scan controller for the bicolour egg-hatch LED matrix: blanking, dwell,
// tear-free buffer swap at frame boundaries, and frame-synchronous blink.
module dz_scan_ctrl
    import dz_pkg::*;
#(
    parameter int unsigned ROWS         = 8,
    parameter int unsigned COLS         = 8,
    parameter int unsigned DWELL        = 4,
    parameter int unsigned BLANK_CYC    = 1,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              blink,
    dz_scan_ctrl_if.slave     bus,
    output logic              frame_start,
    output logic [ROWS-1:0]   row,
    output logic [COLS-1:0]   colr,
    output logic [COLS-1:0]   colg
);

    localparam int unsigned RW         = $clog2(ROWS);
    localparam int unsigned CNT_MAX    = (DWELL > BLANK_CYC) ? DWELL : BLANK_CYC;
    localparam int unsigned CW         = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned FW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int unsigned DWELL_LAST = DWELL - 1;
    localparam int unsigned BLANK_LAST = (BLANK_CYC > 0) ? BLANK_CYC - 1 : 0;
    localparam int unsigned ROW_LAST   = ROWS - 1;
    localparam int unsigned FRM_LAST   = BLINK_FRAMES - 1;

    dz_state_e       state_q, state_d;
    logic [RW-1:0]   row_idx_q, row_idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [FW-1:0]   fcnt_q, fcnt_d;
    logic            phase_q, phase_d;
    logic            pending_q, pending_d;
    logic            boundary_c;
    logic            commit_c;

    logic [ROWS-1:0] row_nx;
    logic [COLS-1:0] colr_nx, colg_nx;
    logic [COLS-1:0] rd_r_c, rd_g_c;

    dz_frame_buf #(.ROWS(ROWS), .COLS(COLS)) u_buf (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (bus.wr_en),
        .wr_row (bus.wr_row),
        .wr_r   (bus.wr_r),
        .wr_g   (bus.wr_g),
        .flip   (commit_c),
        .rd_row (row_idx_d),
        .rd_r_c (rd_r_c),
        .rd_g_c (rd_g_c)
    );

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            row_idx_q     <= '0;
            cnt_q         <= '0;
            fcnt_q        <= '0;
            phase_q       <= 1'b1;
            pending_q     <= 1'b0;
            frame_start   <= 1'b0;
            bus.swap_done <= 1'b0;
            row           <= {ROWS{ROW_OFF}};
            colr          <= '0;
            colg          <= '0;
        end else begin
            state_q       <= state_d;
            row_idx_q     <= row_idx_d;
            cnt_q         <= cnt_d;
            fcnt_q        <= fcnt_d;
            phase_q       <= phase_d;
            pending_q     <= pending_d;
            frame_start   <= boundary_c;
            bus.swap_done <= commit_c;
            row           <= row_nx;
            colr          <= colr_nx;
            colg          <= colg_nx;
        end
    end

    // Scan sequencing, swap pending and blink phase.
    always_comb begin
        state_d    = state_q;
        row_idx_d  = row_idx_q;
        cnt_d      = cnt_q;
        boundary_c = 1'b0;
        if (!en) begin
            state_d   = ST_IDLE;
            row_idx_d = '0;
            cnt_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    boundary_c = 1'b1;
                    row_idx_d  = '0;
                    cnt_d      = '0;
                    state_d    = (BLANK_CYC == 0) ? ST_SHOW : ST_BLANK;
                end
                ST_BLANK: begin
                    if (cnt_q == CW'(BLANK_LAST)) begin
                        cnt_d   = '0;
                        state_d = ST_SHOW;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == CW'(DWELL_LAST)) begin
                        cnt_d   = '0;
                        state_d = (BLANK_CYC == 0) ? ST_SHOW : ST_BLANK;
                        if (row_idx_q == RW'(ROW_LAST)) begin
                            row_idx_d  = '0;
                            boundary_c = 1'b1;
                        end else begin
                            row_idx_d = row_idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        commit_c  = boundary_c && pending_q;
        pending_d = commit_c ? 1'b0 : (pending_q | bus.swap);

        fcnt_d  = fcnt_q;
        phase_d = phase_q;
        if (!blink) begin
            fcnt_d  = '0;
            phase_d = 1'b1;
        end else if (boundary_c) begin
            if (fcnt_q == FW'(FRM_LAST)) begin
                fcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    // Pin drive for the state being entered.
    always_comb begin
        row_nx  = {ROWS{ROW_OFF}};
        colr_nx = '0;
        colg_nx = '0;
        if (state_d == ST_SHOW) begin
            row_nx[row_idx_d] = ~ROW_OFF;
            if (phase_d) begin
                colr_nx = rd_r_c;
                colg_nx = rd_g_c;
            end
        end
    end

endmodule

// File: tb/tb_dz_scan_ctrl.sv
// Directed bench for dz_scan_ctrl: an 8x8 default instance and a 6x4 zero-blank, one-cycle-dwell instance.
module tb_dz_scan_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic en_a, blink_a, en_b, blink_b;

    logic       fs_a;
    logic [7:0] row_a, colr_a, colg_a;
    logic       fs_b;
    logic [5:0] row_b;
    logic [3:0] colr_b, colg_b;

    dz_scan_ctrl_if #(.ROWS(8), .COLS(8)) bus_a ();
    dz_scan_ctrl_if #(.ROWS(6), .COLS(4)) bus_b ();

    dz_scan_ctrl #(.ROWS(8), .COLS(8), .DWELL(4), .BLANK_CYC(1), .BLINK_FRAMES(2)) u_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .blink(blink_a), .bus(bus_a),
        .frame_start(fs_a), .row(row_a), .colr(colr_a), .colg(colg_a)
    );

    dz_scan_ctrl #(.ROWS(6), .COLS(4), .DWELL(1), .BLANK_CYC(0), .BLINK_FRAMES(1)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .blink(blink_b), .bus(bus_b),
        .frame_start(fs_b), .row(row_b), .colr(colr_b), .colg(colg_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       wr_en;
        logic [2:0] wr_row;
        logic [7:0] wr_r;
        logic [7:0] wr_g;
        logic       swap;
        logic [7:0] row;
        logic [7:0] colr;
        logic [7:0] colg;
        logic       fs;
        logic       sd;
    } vec_t;

    vec_t       vecs [12];
    int         checks = 0;
    int         errors = 0;
    int         pos;
    bit         lit;
    logic [7:0] exp_r [8];
    logic [7:0] exp_g [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [7:0] r, input logic [7:0] cr,
                         input logic [7:0] cg, input logic fs, input logic sd);
        chk({tag, ".row"},  32'(row_a),  32'(r));
        chk({tag, ".colr"}, 32'(colr_a), 32'(cr));
        chk({tag, ".colg"}, 32'(colg_a), 32'(cg));
        chk({tag, ".fs"},   32'(fs_a),   32'(fs));
        chk({tag, ".sd"},   32'(bus_a.swap_done), 32'(sd));
    endtask

    task automatic chk_b(input string tag, input logic [5:0] r, input logic [3:0] cr,
                         input logic [3:0] cg, input logic fs, input logic sd);
        chk({tag, ".row"},  32'(row_b),  32'(r));
        chk({tag, ".colr"}, 32'(colr_b), 32'(cr));
        chk({tag, ".colg"}, 32'(colg_b), 32'(cg));
        chk({tag, ".fs"},   32'(fs_b),   32'(fs));
        chk({tag, ".sd"},   32'(bus_b.swap_done), 32'(sd));
    endtask

    // One edge of instance A at frame position pos (40-cycle frame: 1 blank + 4 lit per row).
    task automatic step_a(input logic sd_exp);
        logic [2:0] k;
        int         j;
        logic [7:0] erow, er, eg;
        @(posedge clk); #1;
        k    = 3'(pos / 5);
        j    = pos % 5;
        erow = 8'hFF;
        er   = 8'h00;
        eg   = 8'h00;
        if (j != 0) begin
            erow = ~(8'd1 << k);
            if (lit) begin
                er = exp_r[k];
                eg = exp_g[k];
            end
        end
        chk_a($sformatf("a p%0d", pos), erow, er, eg, logic'(pos == 0), sd_exp);
        pos = (pos + 1) % 40;
        bus_a.wr_en = 1'b0;
        bus_a.swap  = 1'b0;
    endtask

    task automatic set_exp(input logic [7:0] r, input logic [7:0] g);
        for (int i = 0; i < 8; i++) begin
            exp_r[i] = r;
            exp_g[i] = g;
        end
    endtask

    logic [5:0] b_row [6];
    logic [3:0] b_r   [6];
    logic [3:0] b_g   [6];

    initial begin
        // Release frame, writes into the back bank, and a mid-frame swap request.
        vecs[0]  = '{1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 3'd0, 8'h00, 8'h3C, 1'b0, 8'hFE, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 3'd1, 8'h00, 8'h3C, 1'b0, 8'hFE, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 3'd2, 8'h00, 8'h3C, 1'b0, 8'hFE, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 3'd3, 8'h00, 8'h3C, 1'b0, 8'hFE, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 3'd4, 8'h00, 8'h3C, 1'b0, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 3'd5, 8'h00, 8'h3C, 1'b0, 8'hFD, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 3'd6, 8'h00, 8'h3C, 1'b0, 8'hFD, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 3'd7, 8'h00, 8'h3C, 1'b0, 8'hFD, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 8'hFD, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 8'hFB, 8'h00, 8'h00, 1'b0, 1'b0};

        // Instance B edges 2..7 after enable: 6-row walk, 1-cycle dwell, no blanking.
        b_row = '{6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F, 6'h3E};
        b_r   = '{4'hA,  4'h0,  4'h0,  4'h0,  4'h0,  4'h3};
        b_g   = '{4'h5,  4'h0,  4'h0,  4'h0,  4'h0,  4'hC};

        rst_n   = 1'b0;
        en_a    = 1'b1;
        blink_a = 1'b0;
        en_b    = 1'b0;
        blink_b = 1'b0;
        bus_a.wr_en = 1'b0; bus_a.wr_row = '0; bus_a.wr_r = '0; bus_a.wr_g = '0; bus_a.swap = 1'b0;
        bus_b.wr_en = 1'b0; bus_b.wr_row = '0; bus_b.wr_r = '0; bus_b.wr_g = '0; bus_b.swap = 1'b0;

        // Reset held with en high.
        repeat (3) @(posedge clk);
        #1;
        chk_a("a reset", 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0);
        chk_b("b reset", 6'h3F, 4'h0, 4'h0, 1'b0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            en_a         = vecs[i].en;
            bus_a.wr_en  = vecs[i].wr_en;
            bus_a.wr_row = vecs[i].wr_row;
            bus_a.wr_r   = vecs[i].wr_r;
            bus_a.wr_g   = vecs[i].wr_g;
            bus_a.swap   = vecs[i].swap;
            @(posedge clk); #1;
            chk_a($sformatf("a vec%0d", i), vecs[i].row, vecs[i].colr, vecs[i].colg,
                  vecs[i].fs, vecs[i].sd);
        end
        bus_a.wr_en = 1'b0;
        bus_a.swap  = 1'b0;

        // Rest of the first frame still shows the old (cleared) front bank.
        pos = 12;
        lit = 1'b1;
        set_exp(8'h00, 8'h00);
        repeat (28) step_a(1'b0);

        // Commit edge, with a same-cycle write to row 3 of the bank being promoted.
        set_exp(8'h00, 8'h3C);
        exp_r[3] = 8'hFF;
        exp_g[3] = 8'h00;
        bus_a.wr_en  = 1'b1;
        bus_a.wr_row = 3'd3;
        bus_a.wr_r   = 8'hFF;
        bus_a.wr_g   = 8'h00;
        step_a(1'b1);
        repeat (39) step_a(1'b0);

        // Blink with 2-frame half period, enabled just after a frame start.
        step_a(1'b0);
        blink_a = 1'b1;
        repeat (39) step_a(1'b0);
        for (int f = 1; f <= 5; f++) begin
            lit = (f == 1 || f >= 4);
            repeat (40) step_a(1'b0);
        end
        blink_a = 1'b0;
        lit     = 1'b1;

        // Enable drop during row 5, idle write plus swap, then restart at row 0.
        repeat (27) step_a(1'b0);
        en_a = 1'b0;
        @(posedge clk); #1;
        chk_a("a en drop", 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0);
        bus_a.wr_en  = 1'b1;
        bus_a.wr_row = 3'd2;
        bus_a.wr_r   = 8'h81;
        bus_a.wr_g   = 8'h18;
        @(posedge clk); #1;
        chk_a("a idle wr", 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0);
        bus_a.wr_en = 1'b0;
        bus_a.swap  = 1'b1;
        @(posedge clk); #1;
        chk_a("a idle swap", 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0);
        bus_a.swap = 1'b0;
        en_a = 1'b1;
        pos  = 0;
        set_exp(8'h00, 8'h00);
        exp_r[2] = 8'h81;
        exp_g[2] = 8'h18;
        step_a(1'b1);
        repeat (39) step_a(1'b0);

        // Asynchronous reset mid-row with a swap pending.
        repeat (12) step_a(1'b0);
        bus_a.swap = 1'b1;
        step_a(1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_a("a async rst", 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        pos = 0;
        set_exp(8'h00, 8'h00);
        repeat (15) step_a(1'b0);

        // Instance B: out-of-range rows ignored, swap from idle, write forwarded on commit.
        bus_b.wr_en  = 1'b1;
        bus_b.wr_row = 3'd1;
        bus_b.wr_r   = 4'hA;
        bus_b.wr_g   = 4'h5;
        @(posedge clk); #1;
        bus_b.wr_row = 3'd6;
        bus_b.wr_r   = 4'hF;
        bus_b.wr_g   = 4'hF;
        @(posedge clk); #1;
        bus_b.wr_row = 3'd7;
        bus_b.swap   = 1'b1;
        @(posedge clk); #1;
        bus_b.swap   = 1'b0;
        bus_b.wr_row = 3'd0;
        bus_b.wr_r   = 4'h3;
        bus_b.wr_g   = 4'hC;
        en_b = 1'b1;
        @(posedge clk); #1;
        chk_b("b e1", 6'h3E, 4'h3, 4'hC, 1'b1, 1'b1);
        bus_b.wr_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk_b($sformatf("b e%0d", i + 2), b_row[i], b_r[i], b_g[i], logic'(i == 5), 1'b0);
        end
        @(posedge clk); #1;
        chk_b("b e8", 6'h3D, 4'hA, 4'h5, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
